alu_mc: RTL and testbench

Parametrised, multi-cycle successor to the combinational ALU. It adds a valid/ready handshake on both input and output, registered results and flags, and arithmetic-right shift. It also adds an iterative shift-add multiply, plus a signed-overflow flag. It sits between the register file read stage and writeback in the uurisc core, and is also usable as a memory-mapped peripheral.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_iter.sv | 59 +++++
 rtl/alu_mc.sv | 207 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
//   alu_op_e    : operation encodings carried on alu_op (0..10 defined, others illegal)
//   FLAG_*      : bit positions of the flags inside alu_flags
//   alu_state_e : control FSM states of alu_mc
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SRL  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_NAND = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier.
//   clk, rst : clock and synchronous active-high reset (aborts any product in progress)
//   start    : load operands a/b and begin; takes DATA_WIDTH cycles
//   a, b     : operands, sampled only when start is high
//   done     : high for one cycle once the product is complete
//   product  : full 2*DATA_WIDTH-bit product, valid while done is high
module alu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      done,
  output logic [2*DATA_WIDTH-1:0]   product
);
  import alu_pkg::*;

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH) + 1;

  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [CntWidth-1:0]     cnt_q;
  logic                    busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CntWidth'(DATA_WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        // One multiplier bit per cycle, LSB first.
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CntWidth'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done    = busy_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on input and output.
//   clk, rst       : clock and synchronous active-high reset
//   alu_in_valid   : operands/op valid;  alu_in_ready : operation can be accepted
//   alu_a_in       : operand A;  alu_b_in : operand B / shift amount
//   alu_op         : operation (alu_op_e encoding)
//   alu_out_valid  : result valid;  alu_out_ready : consumer takes the result
//   alu_dout       : registered result
//   alu_flags      : registered flags, [3:0] = {V,C,N,Z}, upper bits zero
// Single-cycle ops register their result on the accepting edge; MUL runs in
// alu_mul_iter and presents its result DATA_WIDTH+1 edges after acceptance.
module alu_mc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_in_valid,
  output logic                  alu_in_ready,
  input  logic [DATA_WIDTH-1:0] alu_a_in,
  input  logic [DATA_WIDTH-1:0] alu_b_in,
  input  logic [OP_WIDTH-1:0]   alu_op,
  output logic                  alu_out_valid,
  input  logic                  alu_out_ready,
  output logic [DATA_WIDTH-1:0] alu_dout,
  output logic [DATA_WIDTH-1:0] alu_flags
);
  import alu_pkg::*;

  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned Msb         = DATA_WIDTH - 1;

  alu_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] flags_q, flags_d;

  logic accept;
  logic mul_start, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;

  // Encodings above the defined range fold onto an unused code so they hit the default arm.
  logic [31:0] op_val;
  logic [3:0]  op_sel;
  logic        is_mul;

  assign op_val = 32'(alu_op);
  assign op_sel = (op_val < 32'd11) ? op_val[3:0] : 4'hF;
  assign is_mul = (op_sel == ALU_MUL);

  assign alu_in_ready  = (state_q == IDLE) || ((state_q == DONE) && alu_out_ready);
  assign alu_out_valid = (state_q == DONE);
  assign accept        = alu_in_valid && alu_in_ready;
  assign alu_dout      = dout_q;
  assign alu_flags     = flags_q;

  // Single-cycle datapath
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   shamt_big;
  logic [DATA_WIDTH:0]    sum, diff;
  logic [DATA_WIDTH:0]    srl_ext, sll_ext, sra_ext;

  assign shamt     = alu_b_in[SHAMT_WIDTH-1:0];
  assign shamt_big = |alu_b_in[DATA_WIDTH-1:SHAMT_WIDTH];
  assign sum       = {1'b0, alu_a_in} + {1'b0, alu_b_in};
  assign diff      = {1'b0, alu_a_in} - {1'b0, alu_b_in};
  // An extra bit beside A catches the last bit shifted out; it stays 0 for a zero shift.
  assign srl_ext   = {alu_a_in, 1'b0} >> shamt;
  assign sll_ext   = {1'b0, alu_a_in} << shamt;
  assign sra_ext   = $signed({alu_a_in, 1'b0}) >>> shamt;

  logic [DATA_WIDTH-1:0] sc_res;
  logic                  sc_c, sc_v;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (op_sel)
      ALU_ADD: begin
        sc_res = sum[DATA_WIDTH-1:0];
        sc_c   = sum[DATA_WIDTH];
        sc_v   = (alu_a_in[Msb] == alu_b_in[Msb]) && (sum[Msb] != alu_a_in[Msb]);
      end
      ALU_SUB: begin
        sc_res = diff[DATA_WIDTH-1:0];
        sc_c   = diff[DATA_WIDTH];
        sc_v   = (alu_a_in[Msb] != alu_b_in[Msb]) && (diff[Msb] != alu_a_in[Msb]);
      end
      ALU_SRL: begin
        if (!shamt_big) begin
          sc_res = srl_ext[DATA_WIDTH:1];
          sc_c   = srl_ext[0];
        end
      end
      ALU_SLL: begin
        if (!shamt_big) begin
          sc_res = sll_ext[DATA_WIDTH-1:0];
          sc_c   = sll_ext[DATA_WIDTH];
        end
      end
      ALU_SRA: begin
        if (shamt_big) begin
          sc_res = {DATA_WIDTH{alu_a_in[Msb]}};
          sc_c   = alu_a_in[Msb];
        end else begin
          sc_res = sra_ext[DATA_WIDTH:1];
          sc_c   = sra_ext[0];
        end
      end
      ALU_OR:   sc_res = alu_a_in | alu_b_in;
      ALU_NOR:  sc_res = ~(alu_a_in | alu_b_in);
      ALU_AND:  sc_res = alu_a_in & alu_b_in;
      ALU_NAND: sc_res = ~(alu_a_in & alu_b_in);
      ALU_XOR:  sc_res = alu_a_in ^ alu_b_in;
      default:  sc_res = '0;
    endcase
  end

  // Control FSM and result selection
  logic                  load;
  logic [DATA_WIDTH-1:0] fin_res;
  logic                  fin_c, fin_v;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    mul_start = 1'b0;
    fin_res   = sc_res;
    fin_c     = sc_c;
    fin_v     = sc_v;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = MULT;
            mul_start = 1'b1;
          end else begin
            state_d = DONE;
            load    = 1'b1;
          end
        end
      end
      MULT: begin
        if (mul_done) begin
          state_d = DONE;
          load    = 1'b1;
          fin_res = mul_product[DATA_WIDTH-1:0];
          fin_c   = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
          fin_v   = 1'b0;
        end
      end
      DONE: begin
        if (alu_out_ready) begin
          if (accept) begin
            if (is_mul) begin
              state_d   = MULT;
              mul_start = 1'b1;
            end else begin
              state_d = DONE;
              load    = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    flags_d = flags_q;
    if (load) begin
      dout_d          = fin_res;
      flags_d         = '0;
      flags_d[FLAG_Z] = (fin_res == '0);
      flags_d[FLAG_N] = fin_res[Msb];
      flags_d[FLAG_C] = fin_c;
      flags_d[FLAG_V] = fin_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      flags_q <= flags_d;
    end
  end

  alu_mul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (alu_a_in),
    .b       (alu_b_in),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus randomized ops, with a
// scoreboard queue filled at acceptance and drained by an independent output monitor.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_in_valid = 1'b0;
  logic         alu_in_ready;
  logic [W-1:0] alu_a_in = '0;
  logic [W-1:0] alu_b_in = '0;
  logic [3:0]   alu_op = '0;
  logic         alu_out_valid;
  logic         alu_out_ready = 1'b1;
  logic [W-1:0] alu_dout;
  logic [W-1:0] alu_flags;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  always #5 clk = ~clk;

  alu_mc #(
    .DATA_WIDTH (16),
    .OP_WIDTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_in_valid  (alu_in_valid),
    .alu_in_ready  (alu_in_ready),
    .alu_a_in      (alu_a_in),
    .alu_b_in      (alu_b_in),
    .alu_op        (alu_op),
    .alu_out_valid (alu_out_valid),
    .alu_out_ready (alu_out_ready),
    .alu_dout      (alu_dout),
    .alu_flags     (alu_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: {result, flags} from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [15:0] a16,
                                        input logic [15:0] b16);
    longint a, b, sa, sb_, r;
    bit c, v;
    logic [15:0] r16;
    a  = longint'(a16);
    b  = longint'(b16);
    sa = (a > 32767) ? a - 65536 : a;
    sb_ = (b > 32767) ? b - 65536 : b;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      4'd0: begin r = a + b; c = (r > 65535); v = (sa + sb_ > 32767) || (sa + sb_ < -32768); end
      4'd1: begin r = a - b; c = (a < b);     v = (sa - sb_ > 32767) || (sa - sb_ < -32768); end
      4'd2: if (b < 16) begin
              r = a >> b;
              if (b != 0) c = ((a >> (b - 1)) & 1) != 0;
            end
      4'd3: if (b < 16) begin
              r = a << b;
              if (b != 0) c = ((a >> (16 - b)) & 1) != 0;
            end
      4'd4: if (b >= 16) begin
              r = (sa < 0) ? 65535 : 0;
              c = (sa < 0);
            end else begin
              r = sa >>> b;
              if (b != 0) c = ((a >> (b - 1)) & 1) != 0;
            end
      4'd5:  r = a | b;
      4'd6:  r = ~(a | b);
      4'd7:  r = a & b;
      4'd8:  r = ~(a & b);
      4'd9:  r = a ^ b;
      4'd10: begin r = a * b; c = (r > 65535); end
      default: r = 0;
    endcase
    r16 = 16'(r & 65535);
    return {r16, 12'h000, v, c, r16[15], (r16 == 16'h0000)};
  endfunction

  // Drive one operation until accepted; the expectation is queued on the accepting cycle.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [31:0] exp);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    alu_op = op;
    alu_a_in = a;
    alu_b_in = b;
    alu_in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = alu_in_ready;
      if (acc) sb.push_back(exp);
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: op %0d not accepted in 200 cycles", op);
        acc = 1'b1;
      end
    end
    alu_in_valid = 1'b0;
  endtask

  // Output-ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      alu_out_ready = rand_ready ? ($urandom_range(3) != 0) : ready_force;
    end
  end

  // Monitor: every consumed result is compared with the oldest expectation.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && alu_out_valid && alu_out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h with no result pending",
                   {alu_dout, alu_flags});
        end else begin
          exp = sb.pop_front();
          check("result", {alu_dout, alu_flags}, exp);
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int edges;
    int n;
    bit ir_high;
    logic [3:0] op;
    logic [W-1:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(alu_out_valid), 32'd0);
    check("reset_in_ready", 32'(alu_in_ready), 32'd1);
    check("reset_dout", 32'(alu_dout), 32'd0);
    check("reset_flags", 32'(alu_flags), 32'd0);
    @(posedge clk);
    #1;

    issue(4'd0, 16'h7FFF, 16'h0001, {16'h8000, 16'h000A});
    issue(4'd1, 16'h0003, 16'h0005, {16'hFFFE, 16'h0006});
    issue(4'd4, 16'h8000, 16'h0014, {16'hFFFF, 16'h0006});
    issue(4'd2, 16'h0003, 16'h0001, {16'h0001, 16'h0004});
    issue(4'd3, 16'h8001, 16'h0001, {16'h0002, 16'h0004});
    issue(4'd15, 16'h1234, 16'h5678, {16'h0000, 16'h0001});

    // MUL latency and input stall
    issue(4'd10, 16'h0100, 16'h0100, {16'h0000, 16'h0005});
    edges = 0;
    ir_high = 1'b0;
    do begin
      if (alu_in_ready) ir_high = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end while (!alu_out_valid && edges < 100);
    check("mul_latency", 32'(edges), 32'd17);
    check("mul_in_ready_low", 32'(ir_high), 32'd0);
    idle_cycles(3);

    // Backpressure on an AND result with an XOR waiting
    ready_force = 1'b0;
    issue(4'd7, 16'hFF00, 16'hF0F0, {16'hF000, 16'h0002});
    alu_op = 4'd9;
    alu_a_in = 16'h1234;
    alu_b_in = 16'h1234;
    alu_in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 32'(alu_out_valid), 32'd1);
      check("bp_in_ready", 32'(alu_in_ready), 32'd0);
      check("bp_hold", {alu_dout, alu_flags}, {16'hF000, 16'h0002});
    end
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(alu_in_ready), 32'd1);
    sb.push_back({16'h0000, 16'h0001});
    @(posedge clk);
    #1;
    alu_in_valid = 1'b0;
    @(negedge clk);
    check("bp_xor_next", {15'd0, alu_out_valid, alu_dout, alu_flags},
          {15'd0, 1'b1, 16'h0000, 16'h0001});
    idle_cycles(3);

    // Reset in the middle of a multiply
    issue(4'd10, 16'h1234, 16'h0056, model(4'd10, 16'h1234, 16'h0056));
    idle_cycles(6);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_valid", 32'(alu_out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(alu_in_ready), 32'd1);
    check("rst_mid_dout", 32'(alu_dout), 32'd0);
    check("rst_mid_flags", 32'(alu_flags), 32'd0);
    issue(4'd0, 16'h0002, 16'h0003, {16'h0005, 16'h0000});
    idle_cycles(2);

    // Randomized traffic with random output backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(15));
      a = 16'($urandom);
      b = ($urandom_range(1) == 0) ? 16'($urandom_range(20)) : 16'($urandom);
      if ($urandom_range(7) == 0) a = 16'h8000 | 16'($urandom_range(3));
      issue(op, a, b, model(op, a, b));
      if ($urandom_range(3) == 0) idle_cycles($urandom_range(3));
    end

    rand_ready = 1'b0;
    ready_force = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
